// File: rtl/mem_arbiter_if.sv
// Requester-side and downstream-side buses of mem_arbiter.
// Requesters drive mem_req_if.master; the arbiter drives mem_dn_if.master toward the memory.
interface mem_req_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    write;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    extend;
  logic [NCH*2-1:0]  width;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;

  modport master (output req, addr, write, wdata, extend, width, input ack, rdata);
  modport slave  (input req, addr, write, wdata, extend, width, output ack, rdata);
endinterface

interface mem_dn_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_write;
  logic [DW-1:0] d_wdata;
  logic          d_extend;
  logic [1:0]    d_width;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  modport master (output d_req, d_addr, d_write, d_wdata, d_extend, d_width, input d_ack, d_rdata);
  modport slave  (input d_req, d_addr, d_write, d_wdata, d_extend, d_width, output d_ack, d_rdata);
endinterface

// File: rtl/mem_arbiter.sv
// N-channel request/ack arbiter in front of a single-ported memory, all outputs registered.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module mem_arbiter #(
  parameter  int NCH = 2,
  parameter  int AW  = 32,
  parameter  int DW  = 32,
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  mem_req_if.slave       rq,
  mem_dn_if.master       dn,
  output logic [IDW-1:0] grant_id,
  output logic           busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and latch the winner's command fields
  // BUSY  | d_req high with latched fields, waiting for d_ack
  // RESP  | one-cycle ack to the granted channel; no arbitration
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] win;
  logic           any_req;
  logic [AW-1:0]  sel_addr;
  logic           sel_write;
  logic [DW-1:0]  sel_wdata;
  logic           sel_extend;
  logic [1:0]     sel_width;
  logic [NCH-1:0] ack_d;
  logic           grant_now;

`ifdef MEM_ARB_RR_EN
  logic [IDW-1:0] last_q;
  logic [IDW-1:0] cand;

  // search starts one past the last grant and wraps
  always_comb begin
    win     = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IDW'((int'(last_q) + k) % NCH);
      if (!any_req && rq.req[cand]) begin
        win     = cand;
        any_req = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       last_q <= IDW'(NCH - 1);
    else if (grant_now) last_q <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rq.req[i]) win = IDW'(i);
    end
    any_req = |rq.req;
  end
`endif

  assign grant_now = (state_q == IDLE) && any_req;

  always_comb begin
    sel_addr   = '0;
    sel_write  = 1'b0;
    sel_wdata  = '0;
    sel_extend = 1'b0;
    sel_width  = '0;
    ack_d      = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win == IDW'(i)) begin
        sel_addr   = rq.addr[i*AW +: AW];
        sel_write  = rq.write[i];
        sel_wdata  = rq.wdata[i*DW +: DW];
        sel_extend = rq.extend[i];
        sel_width  = rq.width[i*2 +: 2];
      end
      ack_d[i] = (state_q == BUSY) && dn.d_ack && (grant_id == IDW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (dn.d_ack) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dn.d_req    <= 1'b0;
      dn.d_addr   <= '0;
      dn.d_write  <= 1'b0;
      dn.d_wdata  <= '0;
      dn.d_extend <= 1'b0;
      dn.d_width  <= '0;
      rq.ack      <= '0;
      rq.rdata    <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q  <= state_d;
      dn.d_req <= (state_d == BUSY);
      busy     <= (state_d != IDLE);
      rq.ack   <= ack_d;
      if (grant_now) begin
        dn.d_addr   <= sel_addr;
        dn.d_write  <= sel_write;
        dn.d_wdata  <= sel_wdata;
        dn.d_extend <= sel_extend;
        dn.d_width  <= sel_width;
        grant_id    <= win;
      end
      if (state_q == BUSY && dn.d_ack) rq.rdata <= dn.d_rdata;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel request/ack arbiter that sits between the pipeline's memory requesters and a single-ported backing memory. It generalises the fixed two-port fetch/data hookup to NCH requesters. Each transaction's command fields are latched, so the downstream port sees stable values. Read data and a one-cycle ack are routed back to the granted channel. Arbitration is fixed-priority or round-robin, selected at compile time.

## Interface
Parameters:
- NCH, 2, number of requester channels (1..8); channel 0 is fetch, channel 1 is data by convention
- AW, 32, address width
- DW, 32, data width
- IDW, $clog2(NCH) with a minimum of 1, grant index width (derived; do not override)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NCH  per-channel request; held high until that channel's ack
- addr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW]
- write  in  NCH  per-channel write enable
- wdata  in  NCH*DW  per-channel write data
- extend  in  NCH  per-channel sign-extend for sub-word loads
- width  in  NCH*2  per-channel access width (0 byte, 1 half, 2 word)
- ack  out  NCH  one-cycle pulse to the granted channel
- rdata  out  DW  read data, valid only while the corresponding ack bit is high
- d_req, d_addr[AW], d_write, d_wdata[DW], d_extend, d_width[2]  out  downstream command, driven from latched registers
- d_ack  in  1  downstream completion
- d_rdata  in  DW  downstream read data, valid with d_ack
- grant_id  out  IDW  index of the channel currently owning the port
- busy  out  1  high in BUSY or RESP

## Operation
State machine with three states: IDLE, BUSY, RESP.
- IDLE:
  - If any req bit is set, select a winner by the arbitration policy.
  - Latch that channel's addr/write/wdata/extend/width into the d_* registers and load grant_id.
  - Go to BUSY.
  - If no req bit is set, stay in IDLE.
- BUSY:
  - d_req=1; the d_* fields are held constant.
  - On d_ack=1: capture d_rdata into the rdata register, set ack[grant_id], go to RESP.
- RESP:
  - ack[grant_id]=1 for exactly this cycle; d_req=0.
  - No arbitration in this state, so the acked channel's still-high req is not re-granted.
  - Go to IDLE.
- Arbitration policy: see Configuration. The arbitration pointer updates only on the IDLE→BUSY transition.
- Requester changes to its req/fields while it is granted have no effect; the latched values are used.
- A req that drops before grant is simply not seen.
- ack bits for non-granted channels are always 0. At most one ack bit is high in any cycle.
- Reset mid-transaction: the state returns to IDLE immediately and asynchronously, and the in-flight transaction is abandoned. The downstream memory must also be reset by the same reset_n.

## Timing
- Reset values:
  - state=IDLE, d_req=0, all d_* fields=0, ack=0, rdata=0, grant_id=0, busy=0.
  - Round-robin pointer = NCH-1, so channel 0 wins first.
- Latency, with req sampled high in IDLE at edge 0:
  - d_req is high in cycle 1.
  - If d_ack arrives in cycle k (k≥1), ack is high in cycle k+1.
  - The earliest next grant is decided at the IDLE edge in cycle k+2.
- Back-to-back throughput is one transaction per (downstream latency + 2) cycles. This is accepted cost for the registered outputs.
- d_ack while not in BUSY is ignored.
- A d_ack in the same cycle d_req first rises is legal (zero-wait memory).
- All outputs are registered. There are no combinational paths from req or d_ack to any output.

## Configuration
- MEM_ARB_RR_EN defined:
  - Round-robin arbitration.
  - Search starts at (last_grant+1) mod NCH and wraps; the first requesting channel wins.
  - last_grant updates on each grant.
- MEM_ARB_RR_EN undefined:
  - Fixed priority; the lowest index wins (fetch over data).
  - The pointer register is not built.

## Test plan
- Single request:
  - Stimulus: channel 1 read at addr=0x100, downstream acks 2 cycles after d_req rises with d_rdata=0xDEADBEEF.
  - Expected: d_addr=0x100 from cycle 1; ack=2'b10 for one cycle with rdata=0xDEADBEEF; busy falls the following cycle.
- Simultaneous requests, fixed priority (macro off):
  - Stimulus: ch0 and ch1 both requesting; each requester drops req after its ack.
  - Expected: ch0 granted first (grant_id=0); ch1 granted next; ack sequence 01 then 10.
- Round-robin (MEM_ARB_RR_EN, NCH=4):
  - Stimulus: all four channels request continuously.
  - Expected: grant order 0,1,2,3,0; no channel granted twice before the others.
- Field stability:
  - Stimulus: ch0 changes addr from 0x10 to 0x20 while in BUSY.
  - Expected: d_addr stays at 0x10 until ack.
- Reset mid-op:
  - Stimulus: assert reset_n=0 while in BUSY with d_req=1.
  - Expected: d_req=0, ack=0, and busy=0 immediately; after release, a fresh request completes normally.
- Zero-wait memory:
  - Stimulus: d_ack tied high.
  - Expected: each transaction takes exactly 3 cycles, IDLE→BUSY→RESP; write with width=0 propagates d_width=0 and d_write=1.
